// File: rtl/ffdiv_req_pkg.sv
// Shared types and constants for the ffdiv request controller.
// Holds the FSM state enum, divider flag bit positions and default sizes.
package ffdiv_req_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Divider flag bit positions, {nanf, ovf, inf, uf, zf}
    localparam int NANF = 4;
    localparam int OVF  = 3;
    localparam int INF  = 2;
    localparam int UF   = 1;
    localparam int ZF   = 0;

    localparam int DEF_OPERAND_WIDTH = 32;
    localparam int DEF_FLAG_SIZE     = 5;
    localparam int DEF_TAG_WIDTH     = 4;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int DEF_TIMEOUT       = 64;

    localparam logic [7:0] TO_CNT_MAX = 8'hFF;

    // Saturating increment for the 8-bit timeout statistic
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == TO_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ffdiv_req_fifo.sv
// Request FIFO for the ffdiv controller: stores {tag, op1, op2} entries.
// Ports: clk/rst, push_i/wdata_i write side, pop_i/rdata_o read side
// (rdata_o shows the head combinationally), count_o, full_o, empty_o.
module ffdiv_req_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Writes into a full FIFO and reads from an empty one are dropped
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                // DEPTH is a power of two, so pointers wrap naturally
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ffdiv_req_ctrl.sv
// Initiator side of the ffdiv divider handshake: queues operand pairs,
// issues them one at a time on div_en/div_operand*, waits for div_ready
// (or a timeout) and returns result/flag/itr/tag on the m_* stream.
// Ports: s_* request stream in, m_* response stream out, div_* divider
// side, busy (work pending), timeout_cnt (saturating timeout count).
module ffdiv_req_ctrl
    import ffdiv_req_pkg::*;
#(
    parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH,
    parameter int FLAG_SIZE     = DEF_FLAG_SIZE,
    parameter int TAG_WIDTH     = DEF_TAG_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [OPERAND_WIDTH-1:0]         s_op1,
    input  logic [OPERAND_WIDTH-1:0]         s_op2,
    input  logic [TAG_WIDTH-1:0]             s_tag,

    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [OPERAND_WIDTH-1:0]         m_result,
    output logic [FLAG_SIZE-1:0]             m_flag,
    output logic [$clog2(OPERAND_WIDTH)-1:0] m_itr,
    output logic [TAG_WIDTH-1:0]             m_tag,
    output logic                             m_timeout,

    output logic                             div_en,
    output logic [OPERAND_WIDTH-1:0]         div_operand1,
    output logic [OPERAND_WIDTH-1:0]         div_operand2,
    input  logic                             div_ready,
    input  logic [OPERAND_WIDTH-1:0]         div_result,
    input  logic [FLAG_SIZE-1:0]             div_flag,
    input  logic [$clog2(OPERAND_WIDTH)-1:0] div_itr_count,

    output logic                             busy,
    output logic [7:0]                       timeout_cnt
);

    localparam int ITR_W   = $clog2(OPERAND_WIDTH);
    localparam int ENTRY_W = 2 * OPERAND_WIDTH + TAG_WIDTH;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int WCNT_W  = $clog2(TIMEOUT);

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    // FIFO side
    logic               fifo_push;
    logic               fifo_pop;
    logic [ENTRY_W-1:0] fifo_wdata;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    logic [TAG_WIDTH-1:0]     head_tag;
    logic [OPERAND_WIDTH-1:0] head_op1;
    logic [OPERAND_WIDTH-1:0] head_op2;

    // State and registered outputs
    state_t                   state_q, state_d;
    logic                     div_en_q, div_en_d;
    logic [OPERAND_WIDTH-1:0] op1_q, op1_d;
    logic [OPERAND_WIDTH-1:0] op2_q, op2_d;
    logic [TAG_WIDTH-1:0]     tag_q, tag_d;
    logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
    logic                     m_valid_q, m_valid_d;
    logic [OPERAND_WIDTH-1:0] res_q, res_d;
    logic [FLAG_SIZE-1:0]     flag_q, flag_d;
    logic [ITR_W-1:0]         itr_q, itr_d;
    logic                     mto_q, mto_d;
    logic [7:0]               tocnt_q, tocnt_d;

    // s_ready looks only at occupancy, never at a same-cycle pop
    assign s_ready    = !fifo_full;
    assign fifo_push  = s_valid && s_ready;
    assign fifo_wdata = {s_tag, s_op1, s_op2};

    assign {head_tag, head_op1, head_op2} = fifo_rdata;

    ffdiv_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        div_en_d  = div_en_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        tag_d     = tag_q;
        wcnt_d    = wcnt_q;
        m_valid_d = m_valid_q;
        res_d     = res_q;
        flag_d    = flag_q;
        itr_d     = itr_q;
        mto_d     = mto_q;
        tocnt_d   = tocnt_q;
        fifo_pop  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op1_d    = head_op1;
                    op2_d    = head_op2;
                    tag_d    = head_tag;
                    div_en_d = 1'b1;
                    wcnt_d   = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (div_ready) begin
                    res_d     = div_result;
                    flag_d    = div_flag;
                    itr_d     = div_itr_count;
                    mto_d     = 1'b0;
                    m_valid_d = 1'b1;
                    div_en_d  = 1'b0;
                    state_d   = RESP;
                end else if (wcnt_q == WCNT_LAST) begin
                    // Hung divider: answer with a zeroed abort response
                    res_d     = '0;
                    flag_d    = '0;
                    itr_d     = '0;
                    mto_d     = 1'b1;
                    m_valid_d = 1'b1;
                    div_en_d  = 1'b0;
                    tocnt_d   = sat_inc8(tocnt_q);
                    state_d   = RESP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            RESP: begin
                // Passing through IDLE keeps div_en low between requests
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_en_q  <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            tag_q     <= '0;
            wcnt_q    <= '0;
            m_valid_q <= 1'b0;
            res_q     <= '0;
            flag_q    <= '0;
            itr_q     <= '0;
            mto_q     <= 1'b0;
            tocnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            div_en_q  <= div_en_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            tag_q     <= tag_d;
            wcnt_q    <= wcnt_d;
            m_valid_q <= m_valid_d;
            res_q     <= res_d;
            flag_q    <= flag_d;
            itr_q     <= itr_d;
            mto_q     <= mto_d;
            tocnt_q   <= tocnt_d;
        end
    end

    assign div_en       = div_en_q;
    assign div_operand1 = op1_q;
    assign div_operand2 = op2_q;

    assign m_valid   = m_valid_q;
    assign m_result  = res_q;
    assign m_flag    = flag_q;
    assign m_itr     = itr_q;
    assign m_tag     = tag_q;
    assign m_timeout = mto_q;

    assign busy        = (state_q != IDLE) || (fifo_count != '0);
    assign timeout_cnt = tocnt_q;

endmodule

// File: tb/tb_ffdiv_req_ctrl.sv
// Self-checking bench for ffdiv_req_ctrl with a scripted divider model.
// Expected responses are queued at request time and popped on handshake.
module tb_ffdiv_req_ctrl;
    import ffdiv_req_pkg::*;

    localparam logic [4:0] F_INF = 5'b1 << INF;
    localparam logic [4:0] F_NAN = 5'b1 << NANF;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        int          delay;
        logic [31:0] res;
        logic [4:0]  flag;
        logic [4:0]  itr;
    } mdl_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flag;
        logic [4:0]  itr;
        logic [3:0]  tag;
        logic        to;
    } rsp_t;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  tag;
        int          delay;
        logic [31:0] dres;
        logic [4:0]  dflag;
        logic [4:0]  ditr;
        logic [31:0] exp_res;
        logic [4:0]  exp_flag;
        logic [4:0]  exp_itr;
        logic        exp_to;
        int          exp_en;
    } vec_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        s_valid = 0;
    logic        s_ready;
    logic [31:0] s_op1 = 0;
    logic [31:0] s_op2 = 0;
    logic [3:0]  s_tag = 0;
    logic        m_valid;
    logic        m_ready = 1;
    logic [31:0] m_result;
    logic [4:0]  m_flag;
    logic [4:0]  m_itr;
    logic [3:0]  m_tag;
    logic        m_timeout;
    logic        div_en;
    logic [31:0] div_operand1;
    logic [31:0] div_operand2;
    logic        div_ready;
    logic [31:0] div_result;
    logic [4:0]  div_flag;
    logic [4:0]  div_itr_count;
    logic        busy;
    logic [7:0]  timeout_cnt;

    logic        mdl_rdy = 0;
    logic        spur = 0;
    logic [31:0] mdl_res = 0;
    logic [4:0]  mdl_flag = 0;
    logic [4:0]  mdl_itr = 0;
    int          last_en = 0;

    int nchecks = 0;
    int nfail = 0;

    mdl_t mq[$];
    rsp_t sq[$];
    rsp_t mon_e;
    vec_t tv[5];

    assign div_ready     = mdl_rdy | spur;
    assign div_result    = spur ? 32'hDEADBEEF : mdl_res;
    assign div_flag      = spur ? 5'h1F : mdl_flag;
    assign div_itr_count = spur ? 5'h1F : mdl_itr;

    always #5 clk = ~clk;

    ffdiv_req_ctrl #(
        .OPERAND_WIDTH (32),
        .FLAG_SIZE     (5),
        .TAG_WIDTH     (4),
        .FIFO_DEPTH    (4),
        .TIMEOUT       (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_op1         (s_op1),
        .s_op2         (s_op2),
        .s_tag         (s_tag),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_result      (m_result),
        .m_flag        (m_flag),
        .m_itr         (m_itr),
        .m_tag         (m_tag),
        .m_timeout     (m_timeout),
        .div_en        (div_en),
        .div_operand1  (div_operand1),
        .div_operand2  (div_operand2),
        .div_ready     (div_ready),
        .div_result    (div_result),
        .div_flag      (div_flag),
        .div_itr_count (div_itr_count),
        .busy          (busy),
        .timeout_cnt   (timeout_cnt)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Divider model: on div_en rising, take the next scripted entry and
    // raise div_ready for one cycle 'delay' edges later (0 = never).
    initial begin : model
        int   cnt;
        logic act;
        mdl_t cur;
        act = 0;
        cnt = 0;
        cur = '{0, 0, 0, 0, 0, 0};
        forever begin
            @(posedge clk);
            #1;
            if (act && !div_en) begin
                act     = 0;
                mdl_rdy = 0;
                last_en = cnt;
            end else if (act) begin
                cnt++;
                mdl_rdy = (cur.delay != 0) && (cnt == cur.delay);
            end
            if (!act && div_en) begin
                if (mq.size() == 0) begin
                    nchecks++;
                    nfail++;
                    $display("FAIL unexpected_issue: got op1=%0h expected none",
                             div_operand1);
                    cur = '{0, 0, 0, 0, 0, 0};
                end else begin
                    cur = mq.pop_front();
                    check("issue_operands", {div_operand1, div_operand2},
                          {cur.op1, cur.op2});
                end
                act      = 1;
                cnt      = 1;
                mdl_res  = cur.res;
                mdl_flag = cur.flag;
                mdl_itr  = cur.itr;
                mdl_rdy  = (cur.delay == 1);
            end
        end
    end

    // Response monitor: compares at the negedge before the handshake edge
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sq.size() == 0) begin
                nchecks++;
                nfail++;
                $display("FAIL unexpected_response: got tag=%0h result=%0h expected none",
                         m_tag, m_result);
            end else begin
                mon_e = sq.pop_front();
                check("response",
                      {m_result, m_flag, m_itr, m_tag, m_timeout},
                      {mon_e.res, mon_e.flag, mon_e.itr, mon_e.tag, mon_e.to});
            end
        end
    end

    task automatic push_req(input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] t);
        int   n;
        logic acc;
        s_valid = 1;
        s_op1   = a;
        s_op2   = b;
        s_tag   = t;
        acc     = 0;
        n       = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 0;
        if (!acc) begin
            nchecks++;
            nfail++;
            $display("FAIL push_accept: got s_ready=0 expected 1 within 200 cycles");
        end
    endtask

    task automatic expect_req(input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] t, input int d,
                              input logic [31:0] r, input logic [4:0] f,
                              input logic [4:0] it, input logic to);
        mq.push_back('{a, b, d, r, f, it});
        sq.push_back('{(to ? 32'h0 : r), (to ? 5'h0 : f), (to ? 5'h0 : it), t, to});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sq.size() != 0 || busy) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, {busy, 32'(sq.size())}, 64'h0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] last_res;
        int          n;

        tv[0] = '{32'h40C00000, 32'h40000000, 4'd3, 10, 32'h40400000, 5'd0, 5'd24,
                  32'h40400000, 5'd0, 5'd24, 1'b0, 10};
        tv[1] = '{32'h3F800000, 32'h00000000, 4'd5, 3, 32'h7F800000, F_INF, 5'd1,
                  32'h7F800000, F_INF, 5'd1, 1'b0, 3};
        tv[2] = '{32'h41200000, 32'h40A00000, 4'd7, 0, 32'hAAAAAAAA, 5'h1F, 5'd9,
                  32'h0, 5'd0, 5'd0, 1'b1, 64};
        tv[3] = '{32'h41200000, 32'h40A00000, 4'd9, 1, 32'h40000000, 5'd0, 5'd24,
                  32'h40000000, 5'd0, 5'd24, 1'b0, 1};
        tv[4] = '{32'h00000000, 32'h00000000, 4'd12, 5, 32'h7FC00000, F_NAN, 5'd2,
                  32'h7FC00000, F_NAN, 5'd2, 1'b0, 5};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_div_en", div_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_cnt", timeout_cnt, 0);
        check("rst_m_out", {m_result, m_flag, m_itr, m_tag, m_timeout}, 0);
        rst = 0;
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;

        // Table-driven single requests
        for (int i = 0; i < 5; i++) begin
            mq.push_back('{tv[i].op1, tv[i].op2, tv[i].delay,
                           tv[i].dres, tv[i].dflag, tv[i].ditr});
            sq.push_back('{tv[i].exp_res, tv[i].exp_flag, tv[i].exp_itr,
                           tv[i].tag, tv[i].exp_to});
            push_req(tv[i].op1, tv[i].op2, tv[i].tag);
            wait_drain($sformatf("drain_vec%0d", i));
            check($sformatf("en_cycles_vec%0d", i), last_en, tv[i].exp_en);
        end
        check("timeout_cnt_after_table", timeout_cnt, 1);

        // Back-pressure: five requests, first in flight, four queued
        m_ready  = 0;
        last_res = 0;
        for (int t = 0; t < 5; t++) begin
            a = 32'h1000 + t;
            b = 32'h20 + t;
            last_res = a ^ b;
            expect_req(a, b, 4'(t), 2, last_res, 5'(t), 5'(t), 1'b0);
            push_req(a, b, 4'(t));
        end
        @(negedge clk);
        check("bp_s_ready_full", s_ready, 0);
        check("bp_busy", busy, 1);
        repeat (5) @(posedge clk);
        #1;
        check("bp_hold_valid_tag", {m_valid, m_tag}, {1'b1, 4'd0});
        check("bp_still_full", s_ready, 0);
        m_ready = 1;
        wait_drain("drain_bp");
        check("bp_s_ready_after", s_ready, 1);

        // Spurious div_ready while IDLE
        spur = 1;
        repeat (2) @(posedge clk);
        #1;
        spur = 0;
        check("spur_idle_valid_busy", {m_valid, busy}, 0);
        check("spur_idle_hold", {m_result, m_flag, m_itr}, {last_res, 5'd4, 5'd4});

        // Spurious div_ready while RESP holds a response
        m_ready = 0;
        expect_req(32'h55, 32'h66, 4'd6, 2, 32'hCAFEF00D, 5'b1 << ZF, 5'd7, 1'b0);
        push_req(32'h55, 32'h66, 4'd6);
        n = 0;
        while (!m_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("resp_seen", m_valid, 1);
        spur = 1;
        repeat (3) @(posedge clk);
        #1;
        spur = 0;
        check("spur_resp_hold", {m_valid, m_result, m_tag, m_flag},
              {1'b1, 32'hCAFEF00D, 4'd6, 5'b1 << ZF});
        m_ready = 1;
        wait_drain("drain_spur");

        // Reset mid-WAIT with a second request queued behind it
        mq.push_back('{32'h111, 32'h222, 0, 32'h0, 5'h0, 5'h0});
        mq.push_back('{32'h333, 32'h444, 1, 32'h0, 5'h0, 5'h0});
        push_req(32'h111, 32'h222, 4'd1);
        push_req(32'h333, 32'h444, 4'd2);
        n = 0;
        while (!div_en && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("midwait_en_seen", div_en, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        #1;
        check("midwait_rst_en_valid", {div_en, m_valid}, 0);
        check("midwait_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 0;
        mq.delete();
        spur = 1;
        repeat (2) @(posedge clk);
        #1;
        spur = 0;
        repeat (10) @(posedge clk);
        #1;
        check("midwait_no_resp", {m_valid, busy, div_en}, 0);
        check("midwait_tocnt", timeout_cnt, 0);
        check("midwait_sq_empty", sq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchecks, nfail);
        $finish;
    end

endmodule
